// File: rtl/qos_pkg.sv
// Shared defaults and striping FSM state encoding for the QoS byte striper.
package qos_pkg;

   localparam int DEF_WORD_W   = 32;
   localparam int DEF_BYTE_W   = 8;
   localparam int DEF_NARROW_W = 7;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

endpackage

// File: rtl/qos_narrow_mux.sv
// Registered 2:1 narrow channel mux; the valid flag marks cycles where out_7 was refreshed.
module qos_narrow_mux
   import qos_pkg::*;
#(
   parameter int NARROW_W = DEF_NARROW_W
) (
   input  logic                clk,
   input  logic                reset_L,
   input  logic                enb,
   input  logic [NARROW_W-1:0] in_1,
   input  logic [NARROW_W-1:0] in_2,
   input  logic                selector,
   output logic [NARROW_W-1:0] out_7,
   output logic                out_7_valid
);

   always_ff @(posedge clk) begin
      if (!reset_L) begin
         out_7       <= '0;
         out_7_valid <= 1'b0;
      end else if (enb) begin
         out_7       <= selector ? in_2 : in_1;
         out_7_valid <= 1'b1;
      end else begin
         out_7_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/qos_byte_striper.sv
// Stripes a wide word onto a byte lane MSB first, with a one-entry skid for back-to-back loads,
// alongside a registered narrow pass-through mux.
module qos_byte_striper
   import qos_pkg::*;
#(
   parameter int WORD_W   = DEF_WORD_W,
   parameter int BYTE_W   = DEF_BYTE_W,
   parameter int NARROW_W = DEF_NARROW_W
) (
   input  logic                clk,
   input  logic                reset_L,
   input  logic                ENB,
   input  logic [NARROW_W-1:0] in_1,
   input  logic [NARROW_W-1:0] in_2,
   input  logic                selector,
   input  logic [WORD_W-1:0]   in_3,
   input  logic                selector3,
   output logic [NARROW_W-1:0] out_7,
   output logic                out_7_valid,
   output logic [BYTE_W-1:0]   out_8,
   output logic                out_8_valid,
   output logic [1:0]          byte_idx,
   output logic                busy,
   output logic                overflow
);

   localparam int         NBYTES   = WORD_W / BYTE_W;
   localparam logic [1:0] LAST_IDX = 2'(NBYTES - 1);

   state_t              state, state_d;
   logic [1:0]          cnt, cnt_d;
   logic [WORD_W-1:0]   shreg, shreg_d;
   logic [WORD_W-1:0]   skid_word, skid_word_d;
   logic                skid_valid, skid_valid_d;
   logic                sel3_q, sel3_d;
   logic [BYTE_W-1:0]   out_8_d;
   logic                out_8_valid_d;
   logic                overflow_d;
   logic                load_req;
   logic                drain;
   logic                direct;
   logic                start;
   logic [WORD_W-1:0]   start_word;

   qos_narrow_mux #(
      .NARROW_W (NARROW_W)
   ) u_narrow_mux (
      .clk         (clk),
      .reset_L     (reset_L),
      .enb         (ENB),
      .in_1        (in_1),
      .in_2        (in_2),
      .selector    (selector),
      .out_7       (out_7),
      .out_7_valid (out_7_valid)
   );

   assign byte_idx = cnt;
   assign busy     = (state == SHIFT);

   // A word waiting in the skid is always started before a fresh request, so a
   // request landing on the drain cycle simply refills the skid behind it.
   always_comb begin
      state_d       = state;
      cnt_d         = cnt;
      shreg_d       = shreg;
      skid_word_d   = skid_word;
      skid_valid_d  = skid_valid;
      sel3_d        = sel3_q;
      out_8_d       = out_8;
      out_8_valid_d = 1'b0;
      overflow_d    = 1'b0;
      load_req      = 1'b0;
      drain         = 1'b0;
      direct        = 1'b0;
      start         = 1'b0;
      start_word    = skid_word;

      if (ENB) begin
         sel3_d   = selector3;
         load_req = selector3 & ~sel3_q;
         drain    = skid_valid & ((state == IDLE) | (cnt == LAST_IDX));
         direct   = (state == IDLE) & ~skid_valid;

         case (state)
            IDLE: begin
               if (skid_valid) begin
                  start = 1'b1;
               end else if (load_req) begin
                  start      = 1'b1;
                  start_word = in_3;
               end
            end
            SHIFT: begin
               if (cnt != LAST_IDX) begin
                  shreg_d       = shreg << BYTE_W;
                  out_8_d       = shreg[WORD_W-BYTE_W-1 -: BYTE_W];
                  cnt_d         = cnt + 2'd1;
                  out_8_valid_d = 1'b1;
               end else if (skid_valid) begin
                  start = 1'b1;
               end else begin
                  state_d = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase

         if (start) begin
            state_d       = SHIFT;
            shreg_d       = start_word;
            out_8_d       = start_word[WORD_W-1 -: BYTE_W];
            cnt_d         = 2'd0;
            out_8_valid_d = 1'b1;
         end

         if (drain) begin
            skid_valid_d = 1'b0;
         end
         if (load_req && !direct) begin
            if (!skid_valid || drain) begin
               skid_word_d  = in_3;
               skid_valid_d = 1'b1;
            end else begin
               overflow_d = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_L) begin
         state       <= IDLE;
         cnt         <= 2'd0;
         shreg       <= '0;
         skid_word   <= '0;
         skid_valid  <= 1'b0;
         sel3_q      <= 1'b0;
         out_8       <= '0;
         out_8_valid <= 1'b0;
         overflow    <= 1'b0;
      end else begin
         state       <= state_d;
         cnt         <= cnt_d;
         shreg       <= shreg_d;
         skid_word   <= skid_word_d;
         skid_valid  <= skid_valid_d;
         sel3_q      <= sel3_d;
         out_8       <= out_8_d;
         out_8_valid <= out_8_valid_d;
         overflow    <= overflow_d;
      end
   end

endmodule

// File: tb/tb_qos_byte_striper.sv
// Directed self-checking bench for qos_byte_striper: reset, narrow mux, striping, skid/overflow, stall, abort.
module tb_qos_byte_striper;

   logic        clk = 1'b0;
   logic        reset_L;
   logic        ENB;
   logic [6:0]  in_1;
   logic [6:0]  in_2;
   logic        selector;
   logic [31:0] in_3;
   logic        selector3;
   logic [6:0]  out_7;
   logic        out_7_valid;
   logic [7:0]  out_8;
   logic        out_8_valid;
   logic [1:0]  byte_idx;
   logic        busy;
   logic        overflow;

   int tests_run = 0;
   int failures  = 0;

   qos_byte_striper dut (
      .clk         (clk),
      .reset_L     (reset_L),
      .ENB         (ENB),
      .in_1        (in_1),
      .in_2        (in_2),
      .selector    (selector),
      .in_3        (in_3),
      .selector3   (selector3),
      .out_7       (out_7),
      .out_7_valid (out_7_valid),
      .out_8       (out_8),
      .out_8_valid (out_8_valid),
      .byte_idx    (byte_idx),
      .busy        (busy),
      .overflow    (overflow)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset_L = 1'b0; ENB = 1'b1; in_1 = 7'd3; in_2 = 7'd4; selector = 1'b0;
      in_3 = 32'hFFFF_FFFF; selector3 = 1'b0;
      step(); step();
      tests_run++;
      if ({out_7, out_7_valid} !== 8'h00) begin
         failures++;
         $display("[TB] FAIL reset narrow: got out_7=%0d v=%b, expected 0/0", out_7, out_7_valid);
      end
      tests_run++;
      if ({out_8_valid, byte_idx, out_8, busy, overflow} !== 13'h0) begin
         failures++;
         $display("[TB] FAIL reset stripe: got v=%b idx=%0d out_8=%h busy=%b ovf=%b, expected all 0",
                  out_8_valid, byte_idx, out_8, busy, overflow);
      end
      reset_L = 1'b1;
   endtask

   task automatic test_narrow();
      in_1 = 7'd75; in_2 = 7'd25; selector = 1'b0;
      step();
      tests_run++;
      if ({out_7, out_7_valid} !== {7'd75, 1'b1}) begin
         failures++;
         $display("[TB] FAIL narrow sel0: got %0d/%b, expected 75/1", out_7, out_7_valid);
      end
      selector = 1'b1;
      #1;
      tests_run++;
      if (out_7 !== 7'd75) begin
         failures++;
         $display("[TB] FAIL narrow latency: got %0d before edge, expected 75", out_7);
      end
      step();
      tests_run++;
      if ({out_7, out_7_valid} !== {7'd25, 1'b1}) begin
         failures++;
         $display("[TB] FAIL narrow sel1: got %0d/%b, expected 25/1", out_7, out_7_valid);
      end
      ENB = 1'b0; selector = 1'b0;
      for (int i = 0; i < 2; i++) begin
         step();
         tests_run++;
         if ({out_7, out_7_valid} !== {7'd25, 1'b0}) begin
            failures++;
            $display("[TB] FAIL narrow hold %0d: got %0d/%b, expected 25/0", i, out_7, out_7_valid);
         end
      end
      ENB = 1'b1;
   endtask

   task automatic test_stripe();
      logic [7:0] exp_b [4];
      exp_b = '{8'h87, 8'h8E, 8'h5A, 8'hDE};
      selector3 = 1'b0;
      step();
      in_3 = 32'h878E_5ADE; selector3 = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         selector3 = 1'b0;
         tests_run++;
         if ({out_8_valid, byte_idx, out_8, busy, overflow} !== {1'b1, 2'(i), exp_b[i], 1'b1, 1'b0}) begin
            failures++;
            $display("[TB] FAIL stripe byte %0d: got v=%b idx=%0d out_8=%h busy=%b ovf=%b, expected 1/%0d/%h/1/0",
                     i, out_8_valid, byte_idx, out_8, busy, overflow, i, exp_b[i]);
         end
      end
      step();
      tests_run++;
      if ({out_8_valid, out_8, busy, overflow} !== {1'b0, 8'hDE, 1'b0, 1'b0}) begin
         failures++;
         $display("[TB] FAIL stripe end: got v=%b out_8=%h busy=%b ovf=%b, expected 0/de/0/0",
                  out_8_valid, out_8, busy, overflow);
      end
   endtask

   // Words A,B,C,D: B lands in the skid, C refills it on B's drain cycle, D overflows.
   task automatic test_back_to_back();
      logic        sel3_v [13];
      logic [31:0] word_v [13];
      logic [7:0]  exp_b  [13];
      logic [1:0]  exp_i  [13];
      logic        exp_v  [13];
      logic        exp_o  [13];
      logic [1:0]  idx_seen;
      sel3_v = '{1, 0, 1, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0};
      word_v = '{32'h878E_5ADE, 32'h878E_5ADE, 32'h1234_5678, 32'h1234_5678,
                 32'hCAFE_F00D, 32'hCAFE_F00D, 32'hDEAD_BEEF, 32'hDEAD_BEEF,
                 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
      exp_b  = '{8'h87, 8'h8E, 8'h5A, 8'hDE, 8'h12, 8'h34, 8'h56, 8'h78,
                 8'hCA, 8'hFE, 8'hF0, 8'h0D, 8'h0D};
      exp_i  = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 1, 2, 3, 3};
      exp_v  = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0};
      exp_o  = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0};
      selector3 = 1'b0;
      step();
      for (int i = 0; i < 13; i++) begin
         selector3 = sel3_v[i];
         in_3      = word_v[i];
         step();
         idx_seen = exp_v[i] ? byte_idx : exp_i[i];
         tests_run++;
         if ({out_8_valid, idx_seen, out_8, busy, overflow} !==
             {exp_v[i], exp_i[i], exp_b[i], exp_v[i], exp_o[i]}) begin
            failures++;
            $display("[TB] FAIL b2b edge %0d: got v=%b idx=%0d out_8=%h busy=%b ovf=%b, expected %b/%0d/%h/%b/%b",
                     i, out_8_valid, byte_idx, out_8, busy, overflow,
                     exp_v[i], exp_i[i], exp_b[i], exp_v[i], exp_o[i]);
         end
      end
      step();
      tests_run++;
      if ({out_8_valid, busy, overflow} !== 3'b000) begin
         failures++;
         $display("[TB] FAIL b2b dropped word: got v=%b busy=%b ovf=%b, expected 0/0/0",
                  out_8_valid, busy, overflow);
      end
   endtask

   task automatic test_enable_stall();
      selector3 = 1'b0;
      step();
      in_3 = 32'h878E_5ADE; selector3 = 1'b1;
      step();
      selector3 = 1'b0;
      step();
      tests_run++;
      if ({out_8_valid, byte_idx, out_8} !== {1'b1, 2'd1, 8'h8E}) begin
         failures++;
         $display("[TB] FAIL stall pre: got v=%b idx=%0d out_8=%h, expected 1/1/8e", out_8_valid, byte_idx, out_8);
      end
      ENB = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         tests_run++;
         if ({out_8_valid, byte_idx, out_8, busy, overflow} !== {1'b0, 2'd1, 8'h8E, 1'b1, 1'b0}) begin
            failures++;
            $display("[TB] FAIL stall hold %0d: got v=%b idx=%0d out_8=%h busy=%b ovf=%b, expected 0/1/8e/1/0",
                     i, out_8_valid, byte_idx, out_8, busy, overflow);
         end
      end
      ENB = 1'b1;
      step();
      tests_run++;
      if ({out_8_valid, byte_idx, out_8, busy} !== {1'b1, 2'd2, 8'h5A, 1'b1}) begin
         failures++;
         $display("[TB] FAIL stall resume: got v=%b idx=%0d out_8=%h busy=%b, expected 1/2/5a/1",
                  out_8_valid, byte_idx, out_8, busy);
      end
      step();
      tests_run++;
      if ({out_8_valid, byte_idx, out_8} !== {1'b1, 2'd3, 8'hDE}) begin
         failures++;
         $display("[TB] FAIL stall last: got v=%b idx=%0d out_8=%h, expected 1/3/de", out_8_valid, byte_idx, out_8);
      end
      step();
      tests_run++;
      if ({out_8_valid, busy} !== 2'b00) begin
         failures++;
         $display("[TB] FAIL stall end: got v=%b busy=%b, expected 0/0", out_8_valid, busy);
      end
   endtask

   task automatic test_reset_mid_stripe();
      selector3 = 1'b0;
      step();
      in_3 = 32'h878E_5ADE; selector3 = 1'b1;
      step();
      selector3 = 1'b0;
      step();
      in_3 = 32'h1234_5678; selector3 = 1'b1;
      step();
      reset_L = 1'b0; ENB = 1'b0; selector3 = 1'b0;
      step();
      tests_run++;
      if ({out_7, out_7_valid, out_8_valid, byte_idx, out_8, busy, overflow} !== 21'h0) begin
         failures++;
         $display("[TB] FAIL abort reset: got out_7=%0d v7=%b v=%b idx=%0d out_8=%h busy=%b ovf=%b, expected all 0",
                  out_7, out_7_valid, out_8_valid, byte_idx, out_8, busy, overflow);
      end
      reset_L = 1'b1; ENB = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         tests_run++;
         if ({out_8_valid, out_8, busy, overflow} !== 11'h0) begin
            failures++;
            $display("[TB] FAIL abort after %0d: got v=%b out_8=%h busy=%b ovf=%b, expected 0/00/0/0",
                     i, out_8_valid, out_8, busy, overflow);
         end
      end
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      test_reset();
      test_narrow();
      test_stripe();
      test_back_to_back();
      test_enable_stall();
      test_reset_mid_stripe();
      $display("[TB] %0d tests run, %0d failed", tests_run, failures);
      $finish;
   end

endmodule
